// File: rtl/seg_display_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_display_conv                                             |
// | Description : Sequential binary to seven-segment converter using          |
// |               double-dabble, one bit per clock, with sign display and     |
// |               overflow saturation. SEG_LEADING_BLANK_EN blanks leading    |
// |               zero digits.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_display_conv #(
   parameter int WIDTH   = 8,
   parameter int NDIGITS = 3,
   parameter bit SIGNED  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH-1:0]       value,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [NDIGITS*7-1:0]   digit_seg,
   output logic [6:0]             sign_seg
);

   localparam int BCD_W = (NDIGITS + 1) * 4;
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Active-low segment codes, bit order gfedcba.
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;
   localparam logic [6:0] SEG_TWO   = 7'b0100100;
   localparam logic [6:0] SEG_THREE = 7'b0110000;
   localparam logic [6:0] SEG_FOUR  = 7'b0011001;
   localparam logic [6:0] SEG_FIVE  = 7'b0010010;
   localparam logic [6:0] SEG_SIX   = 7'b0000010;
   localparam logic [6:0] SEG_SEVEN = 7'b1111000;
   localparam logic [6:0] SEG_EIGHT = 7'b0000000;
   localparam logic [6:0] SEG_NINE  = 7'b0010000;
   localparam logic [6:0] SEG_NONE  = 7'b1111111;
   localparam logic [6:0] SEG_NEGA  = 7'b0111111;

`ifdef SEG_LEADING_BLANK_EN
   localparam logic [6:0] SEG_LEAD_RST = SEG_NONE;
`else
   localparam logic [6:0] SEG_LEAD_RST = SEG_ZERO;
`endif

   function automatic logic [NDIGITS*7-1:0] digit_rst_f();
      logic [NDIGITS*7-1:0] r;
      r = '0;
      for (int i = 0; i < NDIGITS; i++)
         r[7*i +: 7] = (i == 0) ? SEG_ZERO : SEG_LEAD_RST;
      return r;
   endfunction

   localparam logic [NDIGITS*7-1:0] DIGIT_RST = digit_rst_f();

   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'd0:    decode = SEG_ZERO;
         4'd1:    decode = SEG_ONE;
         4'd2:    decode = SEG_TWO;
         4'd3:    decode = SEG_THREE;
         4'd4:    decode = SEG_FOUR;
         4'd5:    decode = SEG_FIVE;
         4'd6:    decode = SEG_SIX;
         4'd7:    decode = SEG_SEVEN;
         4'd8:    decode = SEG_EIGHT;
         4'd9:    decode = SEG_NINE;
         default: decode = SEG_NONE;
      endcase
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       mag_q, mag_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   neg_q, neg_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   overflow_q, overflow_d;
   logic [NDIGITS*7-1:0]   digit_seg_q, digit_seg_d;
   logic [6:0]             sign_seg_q, sign_seg_d;

   logic [BCD_W-1:0]       bcd_adj;
   logic [3:0]             nib;
   logic                   guard_nz;
`ifdef SEG_LEADING_BLANK_EN
   logic                   blank;
`endif

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      done_d      = 1'b0;
      overflow_d  = overflow_q;
      digit_seg_d = digit_seg_q;
      sign_seg_d  = sign_seg_q;
      nib         = 4'd0;
      guard_nz    = |bcd_q[BCD_W-1 -: 4];
`ifdef SEG_LEADING_BLANK_EN
      blank       = 1'b1;
`endif

      // Add-3 correction on every nibble, guard nibble included.
      bcd_adj = bcd_q;
      for (int i = 0; i <= NDIGITS; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               neg_d   = SIGNED && value[WIDTH-1];
               mag_d   = neg_d ? -value : value;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = LATCH;
         end
         LATCH: begin
            overflow_d = guard_nz;
            for (int i = NDIGITS - 1; i >= 0; i--) begin
               nib = bcd_q[4*i +: 4];
               if (guard_nz) begin
                  digit_seg_d[7*i +: 7] = SEG_NINE;
               end else begin
`ifdef SEG_LEADING_BLANK_EN
                  if (blank && nib == 4'd0 && i != 0) begin
                     digit_seg_d[7*i +: 7] = SEG_NONE;
                  end else begin
                     blank                 = 1'b0;
                     digit_seg_d[7*i +: 7] = decode(nib);
                  end
`else
                  digit_seg_d[7*i +: 7] = decode(nib);
`endif
               end
            end
            sign_seg_d = neg_q ? SEG_NEGA : SEG_NONE;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mag_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         digit_seg_q <= DIGIT_RST;
         sign_seg_q  <= SEG_NONE;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         digit_seg_q <= digit_seg_d;
         sign_seg_q  <= sign_seg_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign digit_seg = digit_seg_q;
   assign sign_seg  = sign_seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_display_conv                                          |
// | Description : Self-checking bench for seg_display_conv over three         |
// |               configurations; honours SEG_LEADING_BLANK_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_display_conv;

   localparam logic [6:0] NONE = 7'b1111111;
   localparam logic [6:0] NEGA = 7'b0111111;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0]       start_v = '0;
   logic [2:0][15:0] val_p = '0;
   logic [2:0]       busy_v, done_v, ovf_v;
   logic [2:0][6:0]  sign_p;
   logic [20:0]      dig_a;
   logic [13:0]      dig_b;
   logic [34:0]      dig_c;

   int wid [3] = '{8, 8, 16};
   int ndg [3] = '{3, 2, 5};
   bit sgn [3] = '{1'b1, 1'b0, 1'b1};

   logic [34:0] prev_dig  [3];
   logic [6:0]  prev_sign [3];
   logic        prev_ovf  [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seg_display_conv #(.WIDTH(8), .NDIGITS(3), .SIGNED(1'b1)) u_a (
      .clk(clk), .reset(reset), .start(start_v[0]), .value(val_p[0][7:0]),
      .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]),
      .digit_seg(dig_a), .sign_seg(sign_p[0]));

   seg_display_conv #(.WIDTH(8), .NDIGITS(2), .SIGNED(1'b0)) u_b (
      .clk(clk), .reset(reset), .start(start_v[1]), .value(val_p[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]),
      .digit_seg(dig_b), .sign_seg(sign_p[1]));

   seg_display_conv #(.WIDTH(16), .NDIGITS(5), .SIGNED(1'b1)) u_c (
      .clk(clk), .reset(reset), .start(start_v[2]), .value(val_p[2]),
      .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]),
      .digit_seg(dig_c), .sign_seg(sign_p[2]));

   function automatic logic [34:0] dig_of(input int id);
      case (id)
         0:       return {14'd0, dig_a};
         1:       return {21'd0, dig_b};
         default: return dig_c;
      endcase
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         default: return NONE;
      endcase
   endfunction

   function automatic logic [34:0] exp_rst(input int n);
      logic [34:0] r = '0;
      for (int i = 0; i < n; i++) begin
`ifdef SEG_LEADING_BLANK_EN
         r[7*i +: 7] = (i == 0) ? seg_of(0) : NONE;
`else
         r[7*i +: 7] = seg_of(0);
`endif
      end
      return r;
   endfunction

   // Decimal reference: interpret value, split into base-10 digits, saturate.
   task automatic model(input int id, input logic [15:0] v,
                        output logic [34:0] ed, output logic [6:0] es, output logic eo);
      int     w = wid[id];
      int     n = ndg[id];
      longint raw = longint'(v) % (64'd1 << w);
      bit     neg = sgn[id] && (raw >= (64'd1 << (w - 1)));
      longint mag = neg ? (64'd1 << w) - raw : raw;
      longint lim = 1;
      int     d [5];
      bit     lead = 1'b1;
      for (int i = 0; i < n; i++) lim = lim * 10;
      eo = (mag >= lim);
      for (int i = 0; i < n; i++) begin
         d[i] = int'(mag % 10);
         mag  = mag / 10;
      end
      ed = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (eo) begin
            ed[7*i +: 7] = seg_of(9);
         end else begin
`ifdef SEG_LEADING_BLANK_EN
            if (lead && d[i] == 0 && i != 0) begin
               ed[7*i +: 7] = NONE;
            end else begin
               lead = 1'b0;
               ed[7*i +: 7] = seg_of(d[i]);
            end
`else
            ed[7*i +: 7] = seg_of(d[i]);
`endif
         end
      end
      es = neg ? NEGA : NONE;
   endtask

   // Called at a negedge: request conversion on the next rising edge.
   task automatic launch(input int id, input logic [15:0] v);
      prev_dig[id]  = dig_of(id);
      prev_sign[id] = sign_p[id];
      prev_ovf[id]  = ovf_v[id];
      start_v[id]   = 1'b1;
      val_p[id]     = v;
   endtask

   // Follows a launch; returns at the negedge where done is high.
   task automatic wait_check(input int id, input logic [15:0] v, input string nm);
      logic [34:0] ed;
      logic [6:0]  es;
      logic        eo;
      int          lat = 0;
      bit          seen = 1'b0;
      bit          hold_bad = 1'b0;
      model(id, v, ed, es, eo);
      @(posedge clk);
      @(negedge clk);
      start_v[id] = 1'b0;
      val_p[id]   = 16'($urandom);
      while (!seen && lat < 40) begin
         if (busy_v[id] !== 1'b1 || dig_of(id) !== prev_dig[id] ||
             sign_p[id] !== prev_sign[id] || ovf_v[id] !== prev_ovf[id])
            hold_bad = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_v[id] === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (!seen || lat != wid[id] + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, lat, seen, wid[id] + 1);
      end
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL %s hold: busy low or outputs changed mid-conversion", nm);
      end
      n_tests++;
      if (dig_of(id) !== ed) begin
         n_fail++;
         $display("FAIL %s digits: got %h expected %h", nm, dig_of(id), ed);
      end
      n_tests++;
      if (sign_p[id] !== es) begin
         n_fail++;
         $display("FAIL %s sign: got %b expected %b", nm, sign_p[id], es);
      end
      n_tests++;
      if (ovf_v[id] !== eo) begin
         n_fail++;
         $display("FAIL %s overflow: got %b expected %b", nm, ovf_v[id], eo);
      end
      n_tests++;
      if (busy_v[id] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_in_done: got %b expected 0", nm, busy_v[id]);
      end
   endtask

   task automatic conv(input int id, input logic [15:0] v, input string nm);
      launch(id, v);
      wait_check(id, v, nm);
      @(negedge clk);
      n_tests++;
      if (done_v[id] !== 1'b0 || busy_v[id] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: done=%b busy=%b expected 0/0", nm, done_v[id], busy_v[id]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int id = 0; id < 3; id++) begin
         n_tests++;
         if (busy_v[id] !== 1'b0 || done_v[id] !== 1'b0 || ovf_v[id] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags[%0d]: busy=%b done=%b ovf=%b expected 0", id, busy_v[id], done_v[id], ovf_v[id]);
         end
         n_tests++;
         if (dig_of(id) !== exp_rst(ndg[id])) begin
            n_fail++;
            $display("FAIL reset_digits[%0d]: got %h expected %h", id, dig_of(id), exp_rst(ndg[id]));
         end
         n_tests++;
         if (sign_p[id] !== NONE) begin
            n_fail++;
            $display("FAIL reset_sign[%0d]: got %b expected %b", id, sign_p[id], NONE);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      conv(0, 16'h007F, "a_7f");
      conv(0, 16'h0080, "a_80");
      conv(0, 16'h00FF, "a_ff");
      conv(0, 16'h0000, "a_zero");
      conv(1, 16'd200,  "b_200");
      conv(1, 16'd42,   "b_42");
      conv(1, 16'd99,   "b_99");
      conv(1, 16'd100,  "b_100");
      conv(2, 16'h8000, "c_8000");
      conv(2, 16'h7FFF, "c_7fff");
   endtask

   task automatic test_start_while_busy();
      int  dones = 0;
      bit  hold_bad = 1'b0;
      logic [34:0] ed;
      logic [6:0]  es;
      logic        eo;
      conv(0, 16'h007F, "a_pre");
      model(0, 16'h0000, ed, es, eo);
      launch(0, 16'h0000);
      @(posedge clk);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         start_v[0] = (c < 3);
         val_p[0]   = 16'd123;
         if (done_v[0] === 1'b1) dones++;
         if (dones == 0 && (dig_of(0) !== prev_dig[0] || sign_p[0] !== prev_sign[0]))
            hold_bad = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      n_tests++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL busy_start_dones: got %0d expected 1", dones);
      end
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL busy_start_hold: outputs changed before done");
      end
      n_tests++;
      if (dig_of(0) !== ed || sign_p[0] !== es) begin
         n_fail++;
         $display("FAIL busy_start_result: got %h/%b expected %h/%b", dig_of(0), sign_p[0], ed, es);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      conv(0, 16'h0081, "a_pre2");
      launch(0, 16'h007F);
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 ||
          dig_of(0) !== exp_rst(3) || sign_p[0] !== NONE) begin
         n_fail++;
         $display("FAIL mid_reset_state: busy=%b done=%b digits=%h sign=%b expected 0/0/%h/%b",
                  busy_v[0], done_v[0], dig_of(0), sign_p[0], exp_rst(3), NONE);
      end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) dones++;
      end
      n_tests++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL mid_reset_no_done: got %0d pulses expected 0", dones);
      end
      conv(0, 16'h007F, "a_after_reset");
   endtask

   task automatic test_back_to_back();
      logic [15:0] v1, v2, v3;
      v1 = 16'($urandom);
      v2 = 16'($urandom);
      v3 = 16'($urandom);
      launch(0, v1);
      wait_check(0, v1, "b2b_1");
      launch(0, v2);
      wait_check(0, v2, "b2b_2");
      launch(2, v3);
      wait_check(2, v3, "b2b_3");
      launch(2, v1);
      wait_check(2, v1, "b2b_4");
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         int id = k % 3;
         logic [15:0] v = 16'($urandom);
         if (k % 10 == 0) v = 16'd0;
         conv(id, v, "rand");
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_display_conv.md
Name: seg_display_conv

Overview:
- Sequential, parametrised signed/unsigned binary to seven-segment display converter.
- Uses iterative double-dabble (shift/add-3): one bit per clock, replacing a combinational divide/modulo chain.
- Sits between the picoMIPS output register and the board's seven-segment displays.
- Registered segment outputs, start/done handshake, generic width and digit count, overflow saturation.

Parameters:
- WIDTH, 8: input value width in bits.
- NDIGITS, 3: number of decimal digit displays driven.
- SIGNED, 1: 1 = value is two's complement with a separate sign display; 0 = unsigned, sign display always blank.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of value; sampled only in IDLE.
- value  input  WIDTH  number to display; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when new segment outputs are valid.
- overflow  output  1  magnitude exceeded 10^NDIGITS-1 on the last conversion.
- digit_seg  output  NDIGITS*7  segment codes; digit i at bits [7i+6:7i], i=0 is units.
- sign_seg  output  7  sign display code.

Behaviour:
- Segment codes come from the shared number_display.sv codes: ZERO..NINE, NONE, NEGA.
- Reset values: busy=0, done=0, overflow=0, every digit_seg field=ZERO, sign_seg=NONE, FSM=IDLE.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - If start=1 at edge k, capture value.
  - Compute the magnitude: if SIGNED and value[WIDTH-1]=1, magnitude = two's complement negation, held in WIDTH bits unsigned, so -2^(WIDTH-1) maps correctly (e.g. 8'h80 -> 128). Otherwise magnitude = value.
  - Latch the sign flag, clear the BCD accumulator (NDIGITS*4 bits plus 4 carry-guard bits), load the magnitude into the shift register, clear the bit counter, then go to SHIFT.
- SHIFT: each edge:
  - Add 3 to every BCD nibble (including the guard nibble) that is >=5.
  - Then shift {bcd, mag} left by one.
  - After exactly WIDTH shifts (edge k+WIDTH), go to LATCH.
- LATCH: at edge k+WIDTH+1:
  - Set overflow = 1 if the guard nibble is nonzero.
  - If overflow, every digit shows NINE; otherwise each digit shows its BCD nibble.
  - sign_seg = NEGA if the sign flag is set, else NONE.
  - done=1 for exactly one cycle; return to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1 (WIDTH=8: 9 clocks after the start edge).
- busy=1 in SHIFT and LATCH, 0 in IDLE (including the done cycle).
- start while busy=1 is ignored and not queued. start in the done cycle is accepted.
- Outputs hold their last valid values until the next LATCH. They never change mid-conversion.
- Changes on value after the accepting edge have no effect on the current conversion.
- Zero converts to all ZERO with sign NONE. There is no negative zero.
- reset asserted in any state (including mid-SHIFT) wins over start:
  - FSM goes to IDLE.
  - All outputs go to their reset values.
  - The partial result is discarded and done is never pulsed for it.
- Any nibble value >9 is unreachable by construction. Decoding maps it to NONE defensively.

Optional Feature:
- Macro: SEG_LEADING_BLANK_EN.
- Defined:
  - In LATCH, leading zero digits (most significant downward) show NONE instead of ZERO.
  - The units digit always shows its value, so 0 displays as a single ZERO.
  - Overflow saturation digits are never blanked.
  - The reset value of digit_seg becomes NONE for all digits except units=ZERO.
- Undefined: all digits always shown, including leading ZERO.

Test Plan:
- Default params, value=8'h7F, start pulse -> done exactly 9 cycles later; digits (hun,ten,unit)=ONE,TWO,SEVEN; sign NONE; overflow=0.
- value=8'h80 -> ONE,TWO,EIGHT, sign NEGA. value=8'hFF -> ZERO,ZERO,ONE, sign NEGA. With SEG_LEADING_BLANK_EN: NONE,NONE,ONE.
- value=0 -> all ZERO, sign NONE. Then start pulsed on 3 successive cycles while busy -> only one done pulse; outputs unchanged until it.
- WIDTH=8, NDIGITS=2, SIGNED=0, value=200 -> digits NINE,NINE, overflow=1, sign NONE. Next value=42 -> FOUR,TWO, overflow=0.
- Start value=8'h7F, assert reset for 1 cycle at the 4th SHIFT cycle -> busy=0, digits ZERO, sign NONE, no done pulse. A new start after reset converts normally.
- WIDTH=16, NDIGITS=5, value=16'h8000 -> THREE,TWO,SEVEN,SIX,EIGHT, sign NEGA; done 17 cycles after start.
